// File: rtl/pc_sequencer_if.sv
// Fetch-stage request/response bundle between the pipeline control and the next-PC sequencer.
interface pc_sequencer_if #(
  parameter int INST_ADDR_WIDTH = 16
);
  logic [INST_ADDR_WIDTH-1:0] pc_cur;
  logic [INST_ADDR_WIDTH-1:0] branch_target;
  logic [INST_ADDR_WIDTH-1:0] jump_target;
  logic [INST_ADDR_WIDTH-1:0] pc_next;
  logic                       stall;
  logic                       branch_taken;
  logic                       jump;
  logic                       call;
  logic                       ret;
  logic                       halt;
  logic                       fetch_valid;
  logic                       flush;
  logic                       halted;

  modport master (
    output pc_cur, stall, branch_taken, branch_target, jump, jump_target, call, ret, halt,
    input  pc_next, fetch_valid, flush, halted
  );

  modport slave (
    input  pc_cur, stall, branch_taken, branch_target, jump, jump_target, call, ret, halt,
    output pc_next, fetch_valid, flush, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC selection, redirect bubbles and boot/halt sequencing for the fetch stage.
// Optional return-address stack is built when PCSEQ_RAS_EN is defined.
module pc_sequencer #(
  parameter int                         INST_ADDR_WIDTH = 16,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_VECTOR    = '0,
  parameter int                         PC_INCR         = 1,
  parameter int                         BRANCH_PENALTY  = 2,
  parameter int                         RAS_DEPTH       = 4
) (
  input  logic              clk,
  input  logic              rst,
  pc_sequencer_if.slave     bus
);
  localparam int W = INST_ADDR_WIDTH;

  typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;

  state_t       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [W-1:0] pc_seq;
  logic         ret_req;
  logic [W-1:0] ret_addr;
  logic         do_push;
  logic         do_pop;

  assign pc_seq = bus.pc_cur + W'(PC_INCR);

`ifdef PCSEQ_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [W-1:0] ras_mem_q [RAS_DEPTH];
  logic [PW-1:0] top_q, top_d;       // next slot to write
  logic [PW:0]   ras_cnt_q, ras_cnt_d;
  logic [PW-1:0] top_inc, top_dec;

  assign top_inc  = (top_q == PW'(RAS_DEPTH - 1)) ? '0 : top_q + 1'b1;
  assign top_dec  = (top_q == '0) ? PW'(RAS_DEPTH - 1) : top_q - 1'b1;
  assign ret_req  = bus.ret;
  assign ret_addr = (ras_cnt_q == '0) ? RESET_VECTOR : ras_mem_q[top_dec];

  always_comb begin
    top_d     = top_q;
    ras_cnt_d = ras_cnt_q;
    if (do_push) begin
      top_d = top_inc;
      if (ras_cnt_q != (PW + 1)'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + 1'b1;
    end else if (do_pop && (ras_cnt_q != '0)) begin
      top_d     = top_dec;
      ras_cnt_d = ras_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q     <= '0;
      ras_cnt_q <= '0;
    end else begin
      top_q     <= top_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  // Storage needs no reset: an empty count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) ras_mem_q[top_q] <= pc_seq;
  end
`else
  logic unused_ras;

  assign ret_req    = 1'b0;
  assign ret_addr   = RESET_VECTOR;
  assign unused_ras = ^{bus.ret, do_push, do_pop, (RAS_DEPTH != 0)};
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bus.pc_next     = bus.pc_cur;
    bus.fetch_valid = 1'b0;
    bus.flush       = 1'b0;
    bus.halted      = 1'b0;
    do_push         = 1'b0;
    do_pop          = 1'b0;
    case (state_q)
      BOOT: begin
        bus.pc_next = RESET_VECTOR;
        state_d     = RUN;
      end
      HALT: begin
        bus.halted = 1'b1;
      end
      default: begin
        // Bubble countdown keeps running through stalls.
        if (state_q == FLUSH) begin
          if (cnt_q > 3'd1) begin
            cnt_d = cnt_q - 3'd1;
          end else begin
            cnt_d   = '0;
            state_d = RUN;
          end
        end
        if (bus.halt) begin
          state_d = HALT;
        end else if (bus.branch_taken || bus.jump || ret_req) begin
          if (bus.branch_taken) begin
            bus.pc_next = bus.branch_target;
          end else if (bus.jump) begin
            bus.pc_next = bus.jump_target;
            do_push     = bus.call;
          end else begin
            bus.pc_next = ret_addr;
            do_pop      = 1'b1;
          end
          bus.flush = 1'b1;
          cnt_d     = 3'(BRANCH_PENALTY);
          state_d   = FLUSH;
        end else if (!bus.stall) begin
          bus.pc_next     = pc_seq;
          bus.fetch_valid = (state_q == RUN);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
